// File: rtl/mic_recorder.sv
// Codec-domain microphone capture: mixes L/R to 8-bit mono and stores it in a
// dual-port RAM, with immediate or voice-activated start.
module mic_recorder #(
    parameter int         DEPTH  = 8192,
    parameter int         AW     = 13,
    parameter logic [7:0] THRESH = 8'd16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          data_ena,
    input  logic [15:0]   adc_data_l,
    input  logic [15:0]   adc_data_r,
    input  logic          record,
    input  logic          stop,
    input  logic          vox_enable,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic [AW:0]   length,
    output logic [7:0]    peak,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {IDLE, ARMED, REC} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   length_q, length_d;
    logic [7:0]    peak_q, peak_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          rec_prev_q;
    logic [7:0]    rd_data_q;

    logic [7:0]    mem [DEPTH];
    logic          we;
    logic [AW-1:0] waddr;

    logic [16:0]   sum;
    logic [7:0]    mono;
    logic [7:0]    mag;
    logic          rec_req;

    assign sum  = {adc_data_l[15], adc_data_l} + {adc_data_r[15], adc_data_r};
    assign mono = 8'(sum >> 9);
    // -128 has no positive counterpart in 8 bits, so it saturates to 127
    assign mag  = (mono == 8'h80) ? 8'h7F : (mono[7] ? 8'(-mono) : mono);

    // A held record level counts as a single request
    assign rec_req = record & ~rec_prev_q;

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        peak_d   = peak_q;
        done_d   = 1'b0;
        we       = 1'b0;
        waddr    = length_q[AW-1:0];
        unique case (state_q)
            IDLE: begin
                if (rec_req) begin
                    length_d = '0;
                    peak_d   = '0;
                    state_d  = vox_enable ? ARMED : REC;
                end
            end
            ARMED: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (data_ena && (mag >= THRESH)) begin
                    we       = 1'b1;
                    waddr    = '0;
                    length_d = (AW+1)'(1);
                    peak_d   = mag;
                    state_d  = REC;
                end
            end
            REC: begin
                if (stop) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (data_ena) begin
                    we       = 1'b1;
                    length_d = length_q + (AW+1)'(1);
                    if (mag > peak_q) peak_d = mag;
                    if (length_q == (AW+1)'(DEPTH - 1)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            length_q   <= '0;
            peak_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rec_prev_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            length_q   <= length_d;
            peak_q     <= peak_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rec_prev_q <= record;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // Sample storage is deliberately not reset
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= mono;
    end

    assign rd_data = rd_data_q;
    assign length  = length_q;
    assign peak    = peak_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_mic_recorder.sv
// Directed bench for mic_recorder with a 16-sample buffer.
module tb_mic_recorder;

    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          data_ena;
    logic [15:0]   adc_data_l;
    logic [15:0]   adc_data_r;
    logic          record;
    logic          stop;
    logic          vox_enable;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_data;
    logic [AW:0]   length;
    logic [7:0]    peak;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    mic_recorder #(.DEPTH(DEPTH), .AW(AW), .THRESH(8'd16)) dut (
        .clk(clk), .reset(reset), .data_ena(data_ena),
        .adc_data_l(adc_data_l), .adc_data_r(adc_data_r),
        .record(record), .stop(stop), .vox_enable(vox_enable),
        .rd_addr(rd_addr), .rd_data(rd_data), .length(length),
        .peak(peak), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        data_ena = 1'b1;
        adc_data_l = l;
        adc_data_r = r;
        step();
        data_ena = 1'b0;
    endtask

    task automatic pulse_rec();
        record = 1'b1;
        step();
        record = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic chk_word(input string tag, input logic [AW-1:0] a,
                            input logic [7:0] exp);
        rd_addr = a;
        step();
        chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        reset = 1'b1;
        data_ena = 1'b0;
        adc_data_l = '0;
        adc_data_r = '0;
        record = 1'b0;
        stop = 1'b0;
        vox_enable = 1'b0;
        rd_addr = '0;
        step();
        step();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_length", 32'(length), 0);
        chk("rst_peak", 32'(peak), 0);
        chk("rst_rd_data", 32'(rd_data), 0);
        reset = 1'b0;
        step();

        // Immediate record: 0x4000 + 0x4000 = 0x8000 -> mono 0x40
        pulse_rec();
        chk("imm_busy", 32'(busy), 1);
        for (int i = 0; i < 5; i++) frame(16'h4000, 16'h4000);
        chk("imm_len_pre", 32'(length), 5);
        done_cnt = 0;
        pulse_stop();
        chk("imm_done", 32'(done), 1);
        chk("imm_busy_off", 32'(busy), 0);
        step();
        chk("imm_done_1cy", 32'(done), 0);
        chk("imm_done_cnt", 32'(done_cnt), 1);
        chk("imm_length", 32'(length), 5);
        chk("imm_peak", 32'(peak), 32'h40);
        for (int i = 0; i < 5; i++) chk_word("imm_word", 4'(i), 8'h40);

        // Full buffer: L=R=n<<8 gives mono n, frames 17-20 ignored
        done_cnt = 0;
        pulse_rec();
        for (int n = 0; n < 20; n++)
            frame(16'(n << 8), 16'(n << 8));
        step();
        chk("full_length", 32'(length), 16);
        chk("full_busy", 32'(busy), 0);
        chk("full_done_cnt", 32'(done_cnt), 1);
        chk("full_peak", 32'(peak), 32'h0F);
        chk_word("full_w15", 4'd15, 8'h0F);
        chk_word("full_w0", 4'd0, 8'h00);
        chk_word("full_w7", 4'd7, 8'h07);

        // Voice activation: mono 3, -10 discarded; 20, -40 stored
        vox_enable = 1'b1;
        done_cnt = 0;
        pulse_rec();
        chk("vox_busy", 32'(busy), 1);
        frame(16'h0300, 16'h0300);
        frame(16'hF600, 16'hF600);
        chk("vox_len_quiet", 32'(length), 0);
        frame(16'h1400, 16'h1400);
        frame(16'hD800, 16'hD800);
        pulse_stop();
        step();
        chk("vox_length", 32'(length), 2);
        chk("vox_peak", 32'(peak), 40);
        chk("vox_done_cnt", 32'(done_cnt), 1);
        chk_word("vox_w0", 4'd0, 8'h14);
        chk_word("vox_w1", 4'd1, 8'hD8);

        // Arm then stop with only a quiet sample
        done_cnt = 0;
        pulse_rec();
        frame(16'h0300, 16'h0300);
        pulse_stop();
        step();
        step();
        chk("arm_busy", 32'(busy), 0);
        chk("arm_length", 32'(length), 0);
        chk("arm_done_cnt", 32'(done_cnt), 0);

        // Boundaries, then stop together with data_ena
        vox_enable = 1'b0;
        pulse_rec();
        frame(16'h8000, 16'h8000);
        frame(16'h7FFF, 16'h8000);
        stop = 1'b1;
        frame(16'h4000, 16'h4000);
        stop = 1'b0;
        chk("bnd_done", 32'(done), 1);
        chk("bnd_length", 32'(length), 2);
        chk("bnd_peak", 32'(peak), 32'h7F);
        chk_word("bnd_w0", 4'd0, 8'h80);
        chk_word("bnd_w1", 4'd1, 8'hFF);
        chk_word("bnd_w2_kept", 4'd2, 8'h02);

        // Reset mid-recording, then read back with latency check
        pulse_rec();
        frame(16'h2000, 16'h2000);
        frame(16'h2000, 16'h2000);
        rd_addr = 4'd1;
        step();
        chk("mid_rd_pre", 32'(rd_data), 32'h20);
        reset = 1'b1;
        step();
        chk("mid_busy", 32'(busy), 0);
        chk("mid_done", 32'(done), 0);
        chk("mid_length", 32'(length), 0);
        chk("mid_peak", 32'(peak), 0);
        chk("mid_rd_data", 32'(rd_data), 0);
        reset = 1'b0;
        chk_word("post_w0", 4'd0, 8'h20);
        rd_addr = 4'd3;
        #1;
        chk("post_latency", 32'(rd_data), 32'h20);
        step();
        chk("post_w3", 32'(rd_data), 32'h03);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
